// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: issue/retire stage around a 1-cycle registered barrel shifter.
// Accepts shift commands over valid/ready, drives the shifter inputs combinationally,
// tracks the single in-flight op and queues tagged results in a small FIFO.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_valid/o_ready, i_op, i_data,
//   i_shamt, i_tag                    upstream command handshake and payload
//   o_sh_*                            shifter inputs (zero when idle or reserved op)
//   i_sh_result                       shifter output, one cycle after drive
//   o_valid/i_ready, o_result, o_tag,
//   o_err, o_level                    result FIFO head, handshake and occupancy
// DEPTH must be a power of two and at least 2.
module shift_issue_ctrl #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [1:0]               i_op,
  input  logic [31:0]              i_data,
  input  logic [4:0]               i_shamt,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_sh_signed,
  output logic                     o_sh_shift_left,
  output logic [4:0]               o_sh_shift_amt,
  output logic [31:0]              o_sh_data,
  input  logic [31:0]              i_sh_result,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_result,
  output logic [TAG_W-1:0]         o_tag,
  output logic                     o_err,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CRD_W = LVL_W + 1;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic             accept;
  logic             push;
  logic             pop;
  logic             flag;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [CRD_W-1:0] credit;
  entry_t           push_entry;
  entry_t           mem [DEPTH];

  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;
  assign push    = flag;
  assign o_level = count;

  // Slots committed after this edge: queued + in flight - leaving now.
  // pop implies count >= 1, so no underflow.
  assign credit  = CRD_W'(count) + CRD_W'(flag) - CRD_W'(pop);
  assign o_ready = (credit < CRD_W'(DEPTH));
  assign accept  = i_valid & o_ready;

  // Shifter drive; held at zero when nothing legal is being issued.
  always_comb begin
    o_sh_data       = '0;
    o_sh_shift_amt  = '0;
    o_sh_shift_left = 1'b0;
    o_sh_signed     = 1'b0;
    if (accept && (i_op != 2'b11)) begin
      o_sh_data       = i_data;
      o_sh_shift_amt  = i_shamt;
      o_sh_shift_left = (i_op == 2'b00);
      o_sh_signed     = (i_op == 2'b10);
    end
  end

  // In-flight tracker: flag is high exactly in the cycle the shifter result is due.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flag  <= 1'b0;
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      flag <= accept;
      if (accept) begin
        tag_q <= i_tag;
        err_q <= (i_op == 2'b11);
      end
    end
  end

  // Reserved ops still take a slot so ordering is preserved; their result is forced to 0.
  always_comb begin
    push_entry.result = err_q ? 32'h0 : i_sh_result;
    push_entry.tag    = tag_q;
    push_entry.err    = err_q;
  end

  // Storage needs no reset: the head is masked by o_valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation, zero while empty.
  always_comb begin
    o_result = '0;
    o_tag    = '0;
    o_err    = 1'b0;
    if (o_valid) begin
      o_result = mem[rd_ptr].result;
      o_tag    = mem[rd_ptr].tag;
      o_err    = mem[rd_ptr].err;
    end
  end

  a_level_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count <= LVL_W'(DEPTH));

  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && (count == LVL_W'(DEPTH))));

  a_credit_stall: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(((CRD_W'(count) + CRD_W'(flag)) == CRD_W'(DEPTH)) && !pop && o_ready));

endmodule
